// File: rtl/write_buffer_fifo.sv
// Circular write buffer of dirty cache lines, drained oldest-first as one AXI INCR burst per line.
// Optional in-place merge of writes to resident non-draining lines: define WB_MERGE_EN.
module write_buffer_fifo #(
  parameter int DEPTH        = 8,
  parameter int OFFSET_WIDTH = 2,
  parameter int ADDR_WIDTH   = 32,
  localparam int LINE_WORDS  = 1 << OFFSET_WIDTH,
  localparam int LINE_BITS   = 32 * LINE_WORDS,
  localparam int CNT_W       = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [ADDR_WIDTH-1:0] in_addr,
  input  logic [LINE_BITS-1:0]  in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [ADDR_WIDTH-1:0] awaddr,
  output logic [7:0]            awlen,
  output logic                  awvalid,
  input  logic                  awready,
  output logic [31:0]           wdata,
  output logic                  wlast,
  output logic                  wvalid,
  input  logic                  wready,
  input  logic                  bvalid,
  output logic                  bready,
  input  logic [ADDR_WIDTH-1:0] query_addr,
  output logic [LINE_BITS-1:0]  query_data,
  output logic                  query_hit,
  output logic [CNT_W-1:0]      count,
  output logic                  empty
);

  localparam int LINE_LSB = OFFSET_WIDTH + 2;
  localparam int TAG_W    = ADDR_WIDTH - LINE_LSB;
  localparam int PTR_W    = $clog2(DEPTH);
  localparam int BEAT_W   = (OFFSET_WIDTH > 0) ? OFFSET_WIDTH : 1;

  typedef logic [LINE_WORDS-1:0][31:0] line_t;
  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

  line_t            mem  [DEPTH];
  logic [TAG_W-1:0] tags [DEPTH];
  logic [DEPTH-1:0] valid;
  logic [PTR_W-1:0] head, tail, wr_idx;
  logic [BEAT_W-1:0] beat;
  state_t           state;

  logic             full, merge_hit, accept, push, pop;
  logic [PTR_W:0]   q_match;
  logic             unused_addr_bits;

  // Scan backwards from tail-1 so the youngest matching valid entry wins; returns {hit, index}.
  function automatic logic [PTR_W:0] youngest(input logic [TAG_W-1:0] tag);
    logic [PTR_W:0] res;
    int             k;
    res = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      k = int'(tail) + DEPTH - 1 - i;
      if (k >= DEPTH) k = k - DEPTH;
      if (valid[PTR_W'(k)] && tags[PTR_W'(k)] == tag) res = {1'b1, PTR_W'(k)};
    end
    return res;
  endfunction

  always_comb begin
    q_match    = youngest(query_addr[ADDR_WIDTH-1:LINE_LSB]);
    query_hit  = q_match[PTR_W];
    query_data = q_match[PTR_W] ? mem[q_match[PTR_W-1:0]] : '0;
  end

`ifdef WB_MERGE_EN
  logic [PTR_W:0] in_match;

  // The head may only be rewritten before its burst has started.
  always_comb begin
    in_match  = youngest(in_addr[ADDR_WIDTH-1:LINE_LSB]);
    merge_hit = in_match[PTR_W] && !(in_match[PTR_W-1:0] == head && state != IDLE);
    wr_idx    = merge_hit ? in_match[PTR_W-1:0] : tail;
  end
`else
  always_comb begin
    merge_hit = 1'b0;
    wr_idx    = tail;
  end
`endif

  assign full     = (count == CNT_W'(DEPTH));
  assign in_ready = rstn && (!full || merge_hit);
  assign accept   = in_valid && in_ready;
  assign push     = accept && !merge_hit;
  assign pop      = (state == RESP) && bvalid;
  assign empty    = (count == '0);

  assign awaddr = {tags[head], {LINE_LSB{1'b0}}};
  assign awlen  = 8'(LINE_WORDS - 1);
  assign wdata  = mem[head][beat];

  assign unused_addr_bits = ^{in_addr[LINE_LSB-1:0], query_addr[LINE_LSB-1:0]};

  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wr_idx]  <= in_data;
      tags[wr_idx] <= in_addr[ADDR_WIDTH-1:LINE_LSB];
    end
  end

  // Pointer, occupancy and valid bookkeeping; a merge touches none of these.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      valid <= '0;
    end else begin
      if (push) begin
        valid[tail] <= 1'b1;
        tail        <= (tail == PTR_W'(DEPTH - 1)) ? '0 : tail + 1'b1;
      end
      if (pop) begin
        valid[head] <= 1'b0;
        head        <= (head == PTR_W'(DEPTH - 1)) ? '0 : head + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      beat    <= '0;
      awvalid <= 1'b0;
      wvalid  <= 1'b0;
      wlast   <= 1'b0;
      bready  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (count != '0) begin
            state   <= ADDR;
            awvalid <= 1'b1;
          end
        end
        ADDR: begin
          if (awready) begin
            state   <= DATA;
            awvalid <= 1'b0;
            wvalid  <= 1'b1;
            beat    <= '0;
            wlast   <= (LINE_WORDS == 1);
          end
        end
        DATA: begin
          if (wready) begin
            if (wlast) begin
              state  <= RESP;
              wvalid <= 1'b0;
              wlast  <= 1'b0;
              bready <= 1'b1;
            end else begin
              beat  <= beat + 1'b1;
              wlast <= (int'(beat) + 2 == LINE_WORDS);
            end
          end
        end
        RESP: begin
          if (bvalid) begin
            state  <= IDLE;
            bready <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/write_buffer_fifo.md
Name: write_buffer_fifo

Overview:
Parametrised circular write buffer between the data cache's dirty-line eviction path and the AXI write port.
- Accepts whole cache lines and drains them oldest-first as one AXI INCR burst per line, using independent AW/W/B handshakes.
- Supports a combinational youngest-match query so that cache refills can forward buffered data.
- Generalises the earlier fixed 5-entry, 4-beat shift buffer to arbitrary depth and line size.

Parameters:
DEPTH, 8, number of line entries (any value >= 2, not necessarily a power of two)
OFFSET_WIDTH, 2, log2 of 32-bit words per line; LINE_WORDS = 1<<OFFSET_WIDTH
ADDR_WIDTH, 32, byte address width

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
in_addr  in  ADDR_WIDTH  line byte address; low OFFSET_WIDTH+2 bits ignored
in_data  in  32*LINE_WORDS  line data, word 0 in bits [31:0]
in_valid  in  1  enqueue request
in_ready  out  1  enqueue accepted when in_valid && in_ready
awaddr  out  ADDR_WIDTH  burst address, line-aligned (low bits forced 0)
awlen  out  8  constant LINE_WORDS-1
awvalid  out  1  AW valid
awready  in  1  AW ready
wdata  out  32  current beat
wlast  out  1  final beat
wvalid  out  1  W valid
wready  in  1  W ready
bvalid  in  1  write response valid
bready  out  1  write response ready
query_addr  in  ADDR_WIDTH  lookup address
query_data  out  32*LINE_WORDS  youngest matching line, 0 on miss
query_hit  out  1  any valid entry matches
count  out  $clog2(DEPTH+1)  occupied entries
empty  out  1  count==0

Behaviour:
Reset (async, rstn=0):
- head, tail and count go to 0; FSM goes to IDLE.
- awvalid, wvalid, wlast and bready go to 0. in_ready goes to 1 once rstn deasserts.
- Reset mid-burst abandons the burst with no completion.
- Entry valid bits clear; data RAM contents need not be reset.

Enqueue:
- in_ready = (count != DEPTH), combinational.
- On handshake, write the entry at tail; tail advances modulo DEPTH (wraps DEPTH-1 -> 0).

Drain FSM:
- IDLE: when !empty, go to ADDR.
- ADDR: awvalid=1, awaddr = head line address. On awready, go to DATA with beat=0.
- DATA: wvalid=1, wdata = word[beat], wlast = (beat == LINE_WORDS-1). On wready, beat increments; on the last beat, go to RESP.
- RESP: bready=1. On bvalid, pop the head (head advances modulo DEPTH, valid bit cleared) and go to IDLE.
- Minimum occupancy per line: 3 + LINE_WORDS cycles.
- AW and W are never asserted together.
- bresp is ignored.

Occupancy:
- An entry stays valid and queryable until its B handshake.
- Enqueue and pop in the same cycle leave count unchanged.
- With count==DEPTH, a pop in the same cycle does not enable enqueue, because in_ready is based on registered count.

Query:
- Pure combinational. Compare line addresses against every valid entry.
- Priority goes to the youngest entry, counted backwards from tail-1.
- An entry enqueued in cycle N is visible to query from cycle N+1.

Optional Feature:
WB_MERGE_EN
- Defined:
  - If in_addr matches a valid entry that is not the head while FSM != IDLE, the handshake overwrites that entry's data in place. Tail and count do not change.
  - in_ready = !full || merge_hit, so a merge is accepted even when the buffer is full.
  - A match on the head while it is draining allocates a new entry instead.
  - Only the youngest matching entry is merged.
- Undefined: every accepted write allocates a new entry; no in-place update exists.

Test Plan:
- Single line: enqueue addr 0x1000_0004, data words 0x11,0x22,0x33,0x44. With ready held high, expect AW at 0x1000_0000 with awlen=3, beats 0x11..0x44 with wlast on the fourth, pop on bvalid, count returns 0.
- Fill/full, DEPTH=8, awready=0: 8 enqueues give count=8 and in_ready=0. Release awready; lines drain in order 0..7 and wrap head/tail past 7 with no data loss.
- Query priority: enqueue 0x2000 (data A) then 0x2000 (data B). query 0x200C gives hit=1, data=B. query 0x3000 gives hit=0, data=0. After both pop, query 0x2000 gives hit=0.
- Backpressure: toggle wready 1-0-1-0. Each beat is held stable while wvalid && !wready. Hold bvalid low for 5 cycles: entry stays queryable, count stays 1.
- Simultaneous: enqueue in the same cycle as the B handshake with count=3. count stays 3 and the new entry is at the correct tail.
- Reset mid-DATA after beat 1: awvalid, wvalid and bready drop immediately, count=0, query_hit=0. WB_MERGE_EN build: full buffer plus write to a non-head resident address is accepted, count unchanged, query returns new data.
